ib_fetch_ctrl: RTL and testbench
================================

Name: ib_fetch_ctrl

Overview:
- Fetch-side sequencer for the instruction buffer.
- Generates aligned instruction-memory fetch requests and tracks the requests still in flight.
- Converts memory responses into the buffer's push interface (num_pushes / new entry vector), throttled by the buffer's available_slots.
- Sequences branch-mispredict redirects: flushes the buffer, restarts fetch at the new PC, and discards stale responses by epoch.

Parameters:
- PUSH_WIDTH, 4: instructions per fetch block; power of two; equals the buffer's push width.
- MAX_OUTSTANDING, 2: maximum in-flight memory requests.
- EPOCH_BITS, 2: width of the redirect epoch tag.
- RESET_PC, 0: PC loaded on reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  mispredict redirect request.
- redirect_pc  in  32  redirect target PC, word aligned.
- halt  in  1  stop issuing new requests while high.
- ib_available_slots  in  $clog2(PUSH_WIDTH+1)  free push slots reported by the buffer.
- ib_flush  out  1  flush strobe to the buffer.
- ib_num_pushes  out  $clog2(PUSH_WIDTH+1)  number of entries pushed this cycle.
- ib_new_entry  out  FETCH_PACKET[PUSH_WIDTH]  entries to push, packed from index 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  block-aligned fetch address.
- imem_req_tag  out  EPOCH_BITS  epoch of the request.
- imem_resp_valid  in  1  response valid.
- imem_resp_ready  out  1  controller can take the response.
- imem_resp_tag  in  EPOCH_BITS  epoch echoed by memory.
- imem_resp_data  in  32*PUSH_WIDTH  one instruction block.
- outstanding_dbg  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count.
- state_dbg  out  2  current FSM state.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, epoch=0, outstanding=0, holding register empty.
  - All outputs 0, except ib_flush=1 while in reset.
- FSM states: IDLE, RUN, FLUSH, HALTED.
  - IDLE -> RUN on the first clock after reset deasserts.
  - RUN -> FLUSH on redirect_valid.
  - RUN -> HALTED when halt=1 and no redirect is pending.
  - HALTED -> RUN when halt=0.
  - HALTED -> FLUSH on redirect_valid.
  - FLUSH -> RUN after exactly one cycle.
- redirect_valid in any state:
  - Next cycle state=FLUSH; ib_flush=1 for exactly that cycle.
  - fetch_pc=redirect_pc; epoch increments, wrapping modulo 2^EPOCH_BITS.
  - Holding register is cleared; ib_num_pushes=0 in that FLUSH cycle.
  - outstanding is NOT cleared; it still decrements as stale responses return.
  - A redirect on the same cycle as an accepted response: the redirect wins and the response data is dropped.
- Request issue:
  - imem_req_valid=1 only in RUN, with outstanding<MAX_OUTSTANDING and halt=0.
  - imem_req_addr = fetch_pc with the low log2(PUSH_WIDTH)+2 bits cleared.
  - imem_req_tag = current epoch.
  - On handshake: fetch_pc advances to block base + 4*PUSH_WIDTH; outstanding increments.
  - Simultaneous request handshake and response accept leave outstanding unchanged.
- Response handling:
  - imem_resp_ready=1 when the holding register is empty, or will fully drain this cycle.
  - On accept: outstanding decrements.
  - Tag != epoch: the response is discarded.
  - Otherwise the holding register loads instructions from slot offset=pc_low (word index within the block of the first requested PC) to PUSH_WIDTH-1.
    - Only the first response after a redirect can have a nonzero offset; later responses use offset 0.
  - The holding register records its valid count and each entry's PC.
- Push logic (combinational from registered state):
  - ib_num_pushes = min(holding count, ib_available_slots).
  - ib_new_entry[i] = holding entry i for i<ib_num_pushes; remaining entries are 0.
  - Unpushed remainder shifts down to index 0 next cycle; data is never lost or reordered.
  - A response is accepted into the holding register the cycle after it arrives. The earliest push is therefore one cycle after the response handshake.
- Width rules:
  - All counts are unsigned and saturate-free; invariants keep them in range.
  - outstanding never exceeds MAX_OUTSTANDING; the bench checks this with an assertion.

Decomposition:
- Shared package sys_defs.svh holds FETCH_PACKET (inst, pc, valid), the fetch-state enum, and the EPOCH_BITS default.
- One sub-module, fetch_hold_buf: PUSH_WIDTH-entry compacting holding register with load, partial-drain and clear ports.

Test Plan:
- Reset, then redirect to 0x100 with memory always ready and ib_available_slots=4 -> requests issued to 0x100 and 0x110. Each response pushes 4 entries with PCs 0x100..0x11C in order.
- Redirect to 0x108 -> first request address 0x100. First push has ib_num_pushes=2 with PCs 0x108 and 0x10C.
- ib_available_slots=1 for 3 cycles, then 4 -> pushes 1,1,1,1. imem_resp_ready stays low until the holding register drains; no instruction is lost.
- Two requests in flight, redirect to 0x200 -> ib_flush high for one cycle. Both old-epoch responses are dropped with zero pushes; outstanding returns to 0; first new push has PC 0x200.
- Memory withholds responses -> exactly MAX_OUTSTANDING=2 requests issued, then imem_req_valid=0 until a response is accepted.
- Assert reset mid-stream with 2 outstanding and a full holding register -> all outputs 0 immediately (asynchronously). After release, first request address is RESET_PC.

Source files
------------

// File: rtl/ib_fetch_ctrl_pkg.sv
// Shared types for the instruction-buffer fetch sequencer.
// Fetch packet layout and fetch FSM state encoding.
package ib_fetch_ctrl_pkg;

    localparam int EPOCH_BITS_DEF = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } FETCH_PACKET;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ib_fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch control
// and the memory side.
interface ib_fetch_ctrl_if #(
    parameter int PUSH_WIDTH = 4,
    parameter int EPOCH_BITS = 2
);
    logic                    req_valid;
    logic                    req_ready;
    logic [31:0]             req_addr;
    logic [EPOCH_BITS-1:0]   req_tag;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [EPOCH_BITS-1:0]   resp_tag;
    logic [32*PUSH_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_addr, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_tag, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_tag, resp_ready,
        output req_ready, resp_valid, resp_tag, resp_data
    );
endinterface

// File: rtl/ib_fetch_ctrl_hold_buf.sv
// Compacting holding register: loads a packed block, drains from
// index 0 and shifts the remainder down.
module fetch_hold_buf
    import ib_fetch_ctrl_pkg::*;
#(
    parameter  int PUSH_WIDTH = 4,
    localparam int CW         = $clog2(PUSH_WIDTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_load,
    input  FETCH_PACKET   i_load_data [PUSH_WIDTH],
    input  logic [CW-1:0] i_load_cnt,
    input  logic [CW-1:0] i_drain,
    output FETCH_PACKET   o_entry [PUSH_WIDTH],
    output logic [CW-1:0] o_count
);
    FETCH_PACKET   r_entry [PUSH_WIDTH];
    logic [CW-1:0] r_count;
    FETCH_PACKET   w_shift [PUSH_WIDTH];

    always_comb begin
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            w_shift[i] = '0;
            for (int j = 0; j < PUSH_WIDTH; j++) begin
                if (j == i + int'(i_drain)) w_shift[i] = r_entry[j];
            end
        end
    end

    // Load only happens when the old contents drain completely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            for (int i = 0; i < PUSH_WIDTH; i++) r_entry[i] <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            for (int i = 0; i < PUSH_WIDTH; i++) r_entry[i] <= '0;
        end else if (i_load) begin
            r_count <= i_load_cnt;
            r_entry <= i_load_data;
        end else if (i_drain != '0) begin
            r_count <= r_count - i_drain;
            r_entry <= w_shift;
        end
    end

    assign o_entry = r_entry;
    assign o_count = r_count;
endmodule

// File: rtl/ib_fetch_ctrl.sv
// Fetch-side sequencer: issues aligned block fetches, tracks them
// in flight, and feeds responses into the instruction buffer.
module ib_fetch_ctrl
    import ib_fetch_ctrl_pkg::*;
#(
    parameter  int          PUSH_WIDTH      = 4,
    parameter  int          MAX_OUTSTANDING = 2,
    parameter  int          EPOCH_BITS      = EPOCH_BITS_DEF,
    parameter  logic [31:0] RESET_PC        = 32'h0,
    localparam int          CW              = $clog2(PUSH_WIDTH + 1),
    localparam int          OW              = $clog2(MAX_OUTSTANDING + 1),
    localparam int          OFW             = $clog2(PUSH_WIDTH),
    localparam int          AW              = OFW + 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  halt,
    input  logic [CW-1:0]         ib_available_slots,
    output logic                  ib_flush,
    output logic [CW-1:0]         ib_num_pushes,
    output FETCH_PACKET           ib_new_entry [PUSH_WIDTH],
    ib_fetch_ctrl_if.master       imem,
    output logic [OW-1:0]         outstanding_dbg,
    output logic [1:0]            state_dbg
);
    fetch_state_t          r_state, w_next;
    logic [31-AW:0]        r_fetch_blk, r_resp_blk;
    logic [EPOCH_BITS-1:0] r_epoch;
    logic [OW-1:0]         r_out;
    logic [OFW-1:0]        r_offset;
    logic                  w_req_hs, w_resp_hs, w_load, w_unused;
    logic [CW-1:0]         w_hold_cnt, w_num, w_load_cnt;
    FETCH_PACKET           w_hold [PUSH_WIDTH];
    FETCH_PACKET           w_load_data [PUSH_WIDTH];

    assign w_unused = ^redirect_pc[1:0];

    assign imem.req_valid = (r_state == RUN) && !halt &&
                            (r_out < OW'(MAX_OUTSTANDING));
    assign imem.req_addr  = {r_fetch_blk, {AW{1'b0}}};
    assign imem.req_tag   = r_epoch;
    assign w_req_hs       = imem.req_valid && imem.req_ready;

    assign w_num = (w_hold_cnt < ib_available_slots) ?
                   w_hold_cnt : ib_available_slots;
    // Ready when the holding register is empty or drains fully now.
    assign imem.resp_ready = (r_state != IDLE) && (w_hold_cnt == w_num);
    assign w_resp_hs  = imem.resp_valid && imem.resp_ready;
    assign w_load     = w_resp_hs && !redirect_valid &&
                        (imem.resp_tag == r_epoch);
    assign w_load_cnt = CW'(PUSH_WIDTH) - CW'(r_offset);

    always_comb begin
        for (int j = 0; j < PUSH_WIDTH; j++) begin
            w_load_data[j] = '0;
            for (int k = 0; k < PUSH_WIDTH; k++) begin
                if (k == j + int'(r_offset)) begin
                    w_load_data[j].inst  = imem.resp_data[32*k +: 32];
                    w_load_data[j].pc    = {r_resp_blk, OFW'(k), 2'b00};
                    w_load_data[j].valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            ib_new_entry[i] = (i < int'(w_num)) ? w_hold[i] : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        if (redirect_valid) begin
            w_next = FLUSH;
        end else begin
            unique case (r_state)
                IDLE:    w_next = RUN;
                RUN:     if (halt) w_next = HALTED;
                HALTED:  if (!halt) w_next = RUN;
                FLUSH:   w_next = RUN;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_fetch_blk <= RESET_PC[31:AW];
            r_resp_blk  <= RESET_PC[31:AW];
            r_offset    <= RESET_PC[AW-1:2];
            r_epoch     <= '0;
            r_out       <= '0;
        end else begin
            r_state <= w_next;
            if (w_req_hs && !w_resp_hs) r_out <= r_out + OW'(1);
            else if (!w_req_hs && w_resp_hs) r_out <= r_out - OW'(1);
            if (redirect_valid) begin
                r_fetch_blk <= redirect_pc[31:AW];
                r_resp_blk  <= redirect_pc[31:AW];
                r_offset    <= redirect_pc[AW-1:2];
                r_epoch     <= r_epoch + EPOCH_BITS'(1);
            end else begin
                if (w_req_hs) r_fetch_blk <= r_fetch_blk + (32-AW)'(1);
                if (w_load) begin
                    r_offset   <= '0;
                    r_resp_blk <= r_resp_blk + (32-AW)'(1);
                end
            end
        end
    end

    fetch_hold_buf #(.PUSH_WIDTH(PUSH_WIDTH)) u_hold (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_clear     (redirect_valid),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_load_cnt  (w_load_cnt),
        .i_drain     (w_num),
        .o_entry     (w_hold),
        .o_count     (w_hold_cnt)
    );

    assign ib_num_pushes   = w_num;
    assign ib_flush        = !reset || (r_state == FLUSH);
    assign outstanding_dbg = r_out;
    assign state_dbg       = r_state;
endmodule

// File: tb/tb_ib_fetch_ctrl.sv
// Bench for ib_fetch_ctrl: in-order memory model, push-stream
// reference, directed corner sequences and randomized traffic.
module tb_ib_fetch_ctrl;
    import ib_fetch_ctrl_pkg::*;

    localparam int PW = 4;
    localparam int MO = 2;
    localparam int EB = 2;
    localparam logic [31:0] RPC = 32'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid, halt;
    logic [31:0] redirect_pc;
    logic [2:0]  avail;
    logic        ib_flush;
    logic [2:0]  ib_num_pushes;
    FETCH_PACKET ib_new_entry [PW];
    logic [1:0]  outstanding_dbg, state_dbg;

    always #5 clock = ~clock;

    ib_fetch_ctrl_if #(.PUSH_WIDTH(PW), .EPOCH_BITS(EB)) mif ();

    ib_fetch_ctrl #(
        .PUSH_WIDTH(PW), .MAX_OUTSTANDING(MO), .EPOCH_BITS(EB), .RESET_PC(RPC)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .halt               (halt),
        .ib_available_slots (avail),
        .ib_flush           (ib_flush),
        .ib_num_pushes      (ib_num_pushes),
        .ib_new_entry       (ib_new_entry),
        .imem               (mif),
        .outstanding_dbg    (outstanding_dbg),
        .state_dbg          (state_dbg)
    );

    typedef struct { logic [31:0] addr; logic [EB-1:0] tag; } mreq_t;
    typedef struct { logic [2:0] avail; logic [2:0] n; logic [31:0] pc0; logic ready; } vec_t;

    int n_cmp = 0, n_bad = 0;
    mreq_t memq[$];
    logic [31:0] req_log[$], push_pc_log[$];
    int push_n_log[$];
    logic [31:0] exp_pc, exp_req;
    logic [EB-1:0] m_epoch;
    int m_out, good_resp;
    bit m_flush_now, rr_rand, resp_en, resp_rand;
    logic [2:0] s_n;
    logic [31:0] s_pc0;
    logic s_ready, s_flush, s_req_valid;
    vec_t tbl [6];

    function automatic logic [31:0] inst_of(logic [31:0] pc);
        return {~pc[15:0], pc[15:0]};
    endfunction

    function automatic logic [32*PW-1:0] blk_of(logic [31:0] a);
        logic [32*PW-1:0] r;
        for (int k = 0; k < PW; k++) r[32*k +: 32] = inst_of(a + 32'(4*k));
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expire(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not seen within cycle budget", name);
    endtask

    task automatic model_init();
        memq.delete();
        exp_pc = RPC;
        exp_req = RPC & ~32'hF;
        m_epoch = '0;
        m_out = 0;
        m_flush_now = 1'b0;
    endtask

    // One clock: drive memory, sample before the edge, update model.
    task automatic cyc();
        mif.req_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (resp_en && memq.size() > 0 && (!resp_rand || $urandom_range(0, 2) != 0)) begin
            mif.resp_valid = 1'b1;
            mif.resp_tag = memq[0].tag;
            mif.resp_data = blk_of(memq[0].addr);
        end else begin
            mif.resp_valid = 1'b0;
            mif.resp_tag = '0;
            mif.resp_data = '0;
        end
        #4;
        s_n = ib_num_pushes;
        s_pc0 = ib_new_entry[0].pc;
        s_ready = mif.resp_ready;
        s_flush = ib_flush;
        s_req_valid = mif.req_valid;
        chk("push_le_avail", 32'(ib_num_pushes <= avail), 1);
        chk("push_le_width", 32'(ib_num_pushes <= 3'(PW)), 1);
        for (int i = 0; i < PW; i++) begin
            if (i < int'(ib_num_pushes)) begin
                chk("push_valid", 32'(ib_new_entry[i].valid), 1);
                chk("push_pc", ib_new_entry[i].pc, exp_pc);
                chk("push_inst", ib_new_entry[i].inst, inst_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end else begin
                chk("push_unused_zero", 32'(|ib_new_entry[i]), 0);
            end
        end
        if (ib_num_pushes != 0) begin
            push_n_log.push_back(int'(ib_num_pushes));
            push_pc_log.push_back(ib_new_entry[0].pc);
        end
        chk("flush", 32'(ib_flush), 32'(m_flush_now));
        if (m_flush_now) chk("flush_no_push", 32'(ib_num_pushes), 0);
        chk("outstanding", 32'(outstanding_dbg), 32'(m_out));
        if (m_out >= MO || halt) chk("req_gate", 32'(mif.req_valid), 0);
        if (mif.resp_valid && mif.resp_ready) begin
            if (memq[0].tag == m_epoch && !redirect_valid) good_resp++;
            void'(memq.pop_front());
            m_out--;
        end
        if (mif.req_valid && mif.req_ready) begin
            chk("req_addr", mif.req_addr, exp_req);
            chk("req_tag", 32'(mif.req_tag), 32'(m_epoch));
            memq.push_back('{addr: mif.req_addr, tag: mif.req_tag});
            req_log.push_back(mif.req_addr);
            exp_req = exp_req + 32'(4*PW);
            m_out++;
        end
        m_flush_now = redirect_valid;
        if (redirect_valid) begin
            exp_pc = redirect_pc;
            exp_req = redirect_pc & ~32'hF;
            m_epoch = m_epoch + 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_redirect(logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        cyc();
        redirect_valid = 1'b0;
        req_log.delete();
        push_n_log.delete();
        push_pc_log.delete();
    endtask

    task automatic wait_out(int target, string name);
        int b = 0;
        while (m_out != target && b < 30) begin cyc(); b++; end
        if (m_out != target) expire(name);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_flush"}, 32'(ib_flush), 1);
        chk({tag, "_pushes"}, 32'(ib_num_pushes), 0);
        chk({tag, "_req_valid"}, 32'(mif.req_valid), 0);
        chk({tag, "_resp_ready"}, 32'(mif.resp_ready), 0);
        chk({tag, "_outstanding"}, 32'(outstanding_dbg), 0);
        chk({tag, "_state"}, 32'(state_dbg), 0);
        chk({tag, "_addr"}, mif.req_addr, 0);
        chk({tag, "_tag"}, 32'(mif.req_tag), 0);
        for (int i = 0; i < PW; i++) chk({tag, "_entry"}, 32'(|ib_new_entry[i]), 0);
    endtask

    always @(negedge clock) begin
        if (reset) assert (outstanding_dbg <= 2'(MO))
            else $error("FAIL outstanding_bound: got %0d want <= %0d", outstanding_dbg, MO);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, g0, np;
        tbl[0] = '{3'd0, 3'd0, 32'h0,   1'b0};
        tbl[1] = '{3'd1, 3'd1, 32'h100, 1'b0};
        tbl[2] = '{3'd1, 3'd1, 32'h104, 1'b0};
        tbl[3] = '{3'd1, 3'd1, 32'h108, 1'b0};
        tbl[4] = '{3'd4, 3'd1, 32'h10C, 1'b1};
        tbl[5] = '{3'd4, 3'd0, 32'h0,   1'b1};
        redirect_valid = 0; redirect_pc = 0; halt = 0; avail = 3'd4;
        mif.req_ready = 0; mif.resp_valid = 0; mif.resp_tag = 0; mif.resp_data = 0;
        rr_rand = 0; resp_en = 1; resp_rand = 0; good_resp = 0;
        model_init();
        #3;
        check_reset_outputs("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        run(2);
        chk("first_req_reset_pc", req_log[0], RPC);

        do_redirect(32'h100);
        run(14);
        chk("t1_req0", req_log[0], 32'h100);
        chk("t1_req1", req_log[1], 32'h110);
        chk("t1_push0_n", 32'(push_n_log[0]), 4);
        chk("t1_push0_pc", push_pc_log[0], 32'h100);
        chk("t1_push1_n", 32'(push_n_log[1]), 4);
        chk("t1_push1_pc", push_pc_log[1], 32'h110);

        do_redirect(32'h108);
        run(14);
        chk("t2_req0", req_log[0], 32'h100);
        chk("t2_push0_n", 32'(push_n_log[0]), 2);
        chk("t2_push0_pc", push_pc_log[0], 32'h108);
        chk("t2_push1_pc", push_pc_log[1], 32'h110);

        avail = 3'd0;
        do_redirect(32'h100);
        g0 = good_resp; b = 0;
        while (good_resp == g0 && b < 30) begin cyc(); b++; end
        if (good_resp == g0) expire("t3_load_wait");
        resp_en = 0;
        for (int r = 0; r < 6; r++) begin
            avail = tbl[r].avail;
            cyc();
            chk("tbl_n", 32'(s_n), 32'(tbl[r].n));
            chk("tbl_pc0", s_pc0, tbl[r].pc0);
            chk("tbl_ready", 32'(s_ready), 32'(tbl[r].ready));
        end
        resp_en = 1;
        run(16);

        resp_en = 0; avail = 3'd4;
        wait_out(2, "t4_fill");
        halt = 1;
        do_redirect(32'h200);
        cyc();
        chk("t4_flush_pulse", 32'(s_flush), 1);
        resp_en = 1;
        cyc();
        chk("t4_flush_end", 32'(s_flush), 0);
        wait_out(0, "t4_drain");
        chk("t4_out_zero", 32'(outstanding_dbg), 0);
        chk("t4_no_stale_push", 32'(push_n_log.size()), 0);
        halt = 0; b = 0;
        while (push_pc_log.size() == 0 && b < 30) begin cyc(); b++; end
        chk("t4_first_pc", push_pc_log[0], 32'h200);

        halt = 1;
        wait_out(0, "t5_drain");
        halt = 0; resp_en = 0;
        do_redirect(32'h300);
        run(10);
        chk("t5_req_count", 32'(req_log.size()), 32'(MO));
        chk("t5_req_stall", 32'(s_req_valid), 0);
        resp_en = 1; b = 0;
        while (req_log.size() < 3 && b < 20) begin cyc(); b++; end
        chk("t5_req_resume", 32'(req_log.size()), 3);

        avail = 3'd0;
        do_redirect(32'h400);
        run(12);
        chk("t6_out_two", 32'(outstanding_dbg), 2);
        chk("t6_hold_full", 32'(s_ready), 0);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mif.resp_valid = 0;
        model_init();
        @(negedge clock);
        reset = 1'b1;
        avail = 3'd4;
        req_log.delete();
        run(4);
        chk("t6_req_reset_pc", req_log[0], RPC);

        rr_rand = 1; resp_rand = 1;
        for (int c = 0; c < 1500; c++) begin
            avail = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 24) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            cyc();
        end
        redirect_valid = 0; halt = 0;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
